// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the EX stage. MULT/MULTU use LSB-first
// shift-add and DIV/DIVU use MSB-first restoring division, both over WIDTH
// iterations. A sign fix-up pass follows, then a single DONE cycle commits
// the result to HI/LO. The unit holds the pipeline stalled until the result
// is committed.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFixup, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             is_div_q;
  logic             neg_lo_q;   // product sign (mult) or quotient sign (div)
  logic             neg_hi_q;   // product sign (mult) or remainder sign (div)
  logic             dbz_q;
  logic [WIDTH-1:0] opnd_q;     // |multiplicand| or |divisor|
  logic [WIDTH-1:0] acc_hi_q;   // product high half or partial remainder
  logic [WIDTH-1:0] acc_lo_q;   // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_out_q;
  logic             busy_q;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ok;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // Operand magnitudes; only the signed ops (op[0]=1) take an absolute value.
  // The most negative value maps onto itself and is treated as unsigned.
  always_comb begin
    sign_a = op[0] & srcA[WIDTH-1];
    sign_b = op[0] & srcB[WIDTH-1];
    abs_a  = sign_a ? (~srcA + 1'b1) : srcA;
    abs_b  = sign_b ? (~srcB + 1'b1) : srcB;
  end

  // One shift-add or restoring-divide step on the accumulator pair.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){acc_lo_q[0]}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opnd_q});
    // When the trial succeeds the difference is below the divisor, so it fits in WIDTH bits.
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      iter_hi = div_ok ? div_sub : div_shift[WIDTH-1:0];
      iter_lo = {acc_lo_q[WIDTH-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the unsigned result. With a zero divisor the restoring loop
  // leaves |A| as the remainder and all ones as the quotient. Applying the
  // remainder sign restores raw srcA, and the quotient is left as all ones.
  always_comb begin
    prod_neg = ~{acc_hi_q, acc_lo_q} + 1'b1;
    if (is_div_q) begin
      fix_hi = neg_hi_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
      fix_lo = (neg_lo_q && !dbz_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
    end else if (neg_lo_q) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end else begin
      fix_hi = acc_hi_q;
      fix_lo = acc_lo_q;
    end
  end

  // Sequencer FSM with registered busy/done/div_by_zero and the HI/LO result registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dbz_q     <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            is_div_q <= op[1];
            neg_lo_q <= sign_a ^ sign_b;
            neg_hi_q <= op[1] ? sign_a : (sign_a ^ sign_b);
            dbz_q    <= op[1] & ~|srcB;
            opnd_q   <= op[1] ? abs_b : abs_a;
            acc_lo_q <= op[1] ? abs_a : abs_b;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_hi_q <= iter_hi;
            acc_lo_q <= iter_lo;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q <= StFixup;
            end
          end
        end
        StFixup: begin
          busy_q <= 1'b0;
          if (flush) begin
            state_q <= StIdle;
          end else begin
            hi_q      <= fix_hi;
            lo_q      <= fix_lo;
            done_q    <= 1'b1;
            dbz_out_q <= dbz_q;
            state_q   <= StDone;
          end
        end
        // Result is already committed; start and flush are both ignored here.
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the issuing instruction freezes in EX at once.
  // It is forced low while reset is held.
  always_comb begin
    stall = resetn & (((state_q == StIdle) & start & ~flush) | busy_q);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed bench for muldiv_sequencer against a plain-arithmetic model.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         stall;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .op          (op),
    .srcA        (srcA),
    .srcB        (srcB),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result {hi, lo} computed with wide integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: res = {32'b0, a} * {32'b0, b};
      2'b01: res = sa * sb;
      default: begin
        if (b == 0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          res = {a % b, a / b};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issue one op one cycle after the call. Optional flush or reset at post-start cycle N.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int flush_at, input int rst_at);
    logic [63:0] r;
    int cyc;
    bit fin;
    @(posedge clock);
    @(negedge clock);
    check_eq("bubble_ctl", {busy, done, div_by_zero}, 3'b000);
    check_eq("hold_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    r = ref_result(o, a, b);
    start = 1'b1; flush = 1'b0; op = o; srcA = a; srcB = b;
    #1 check_eq("idle_stall", stall, 1'b1);
    cyc = 0;
    fin = 0;
    while (!fin) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (cyc > 4 * W) begin
        check_eq("done_timeout", done, 1'b1);
        start = 1'b0;
        fin = 1;
      end else if (cyc == flush_at) begin
        flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("flush_ctl", {stall, busy, done, div_by_zero}, 4'b0000);
        check_eq("flush_hilo", {hi, lo}, {mdl_hi, mdl_lo});
        start = 1'b0;
        flush = 1'b0;
        fin = 1;
      end else if (cyc == rst_at) begin
        resetn = 1'b0;
        #1;
        check_eq("rst_ctl", {stall, busy, done, div_by_zero}, 4'b0000);
        check_eq("rst_hilo", {hi, lo}, 64'h0);
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clock);
        resetn = 1'b1;
        cyc = 0;
        rst_at = -1;
      end else if (done) begin
        check_eq("latency", cyc, W + 2);
        check_eq("result", {hi, lo}, r);
        check_eq("done_ctl", {stall, busy, div_by_zero}, {2'b00, (o[1] && b == 0)});
        mdl_hi = r[63:32];
        mdl_lo = r[31:0];
        fin = 1;
      end else begin
        check_eq("run_ctl", {stall, busy, done, div_by_zero}, 4'b1100);
      end
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(negedge clock);
    check_eq("reset_state", {stall, busy, done, div_by_zero, hi, lo}, 68'h0);
    resetn = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check_eq("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, -1, -1);
    check_eq("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, -1);
    check_eq("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    do_op(2'b10, 32'd5, 32'd0, -1, -1);
    check_eq("divu_zero", {hi, lo, div_by_zero}, {64'h0000_0005_FFFF_FFFF, 1'b1});
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    check_eq("div_ovf", {hi, lo, div_by_zero}, {64'h0000_0000_8000_0000, 1'b0});

    do_op(2'b00, 32'h8000_0001, 32'h22, -1, -1);
    check_eq("load_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    do_op(2'b10, 32'd100, 32'd7, 10, -1);
    do_op(2'b10, 32'd100, 32'd7, -1, -1);
    check_eq("divu_reissue", {hi, lo}, 64'h0000_0002_0000_000E);
    do_op(2'b11, 32'hFFFF_FFF7, 32'd2, W + 1, -1);

    do_op(2'b01, 32'hFFFF_1234, 32'h00AB_CDEF, -1, 15);

    // start with flush in IDLE must not begin an operation
    @(posedge clock);
    @(negedge clock);
    start = 1'b1; flush = 1'b1; op = 2'b00; srcA = 32'd3; srcB = 32'd3;
    #1 check_eq("idle_flush_stall", stall, 1'b0);
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check_eq("idle_flush_ctl", {stall, busy, done}, 3'b000);
    end
    start = 1'b0;
    flush = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = ($urandom_range(0, 1) != 0) ? 32'h1 : 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(ro, ra, rb, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
